pmem_burst_adapter: RTL and testbench



---
 rtl/pmem_burst_adapter.sv | 178 +++++++++++++++++
 tb/tb_pmem_burst_adapter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_burst_adapter.sv
// Splits 256-bit line reads/writes into four 64-bit beats and reassembles read beats into a line.
// Optional feature macro PMEM_BURST_GUARD_EN: after each completion, ignore requests for GUARD_CYCLES cycles.
module pmem_burst_adapter #(
    parameter int BEAT_WIDTH   = 64,
    parameter int LINE_WIDTH   = 256,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [15:0]           mem_address,
    input  logic [LINE_WIDTH-1:0] mem_wdata,
    output logic                  mem_resp,
    output logic [LINE_WIDTH-1:0] mem_rdata,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [15:0]           bmem_address,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_resp,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata
);
    localparam int NBEATS    = LINE_WIDTH / BEAT_WIDTH;
    localparam int BEAT_BITS = $clog2(NBEATS);
    localparam int BYTE_BITS = $clog2(BEAT_WIDTH / 8);
    localparam logic [15:0] LINE_MASK = 16'hFFFF << (BEAT_BITS + BYTE_BITS);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(NBEATS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
`ifdef PMEM_BURST_GUARD_EN
    localparam logic [2:0] S_GUARD = 3'd4;
    localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
`endif

    if ((NBEATS < 2) || ((NBEATS & (NBEATS - 1)) != 0) || (GUARD_CYCLES < 0)) begin : g_bad_cfg
        $error("pmem_burst_adapter: unsupported parameter combination");
    end

    logic [2:0]            state_q, state_d;
    logic [BEAT_BITS-1:0]  beat_q, beat_d;
    logic [15:0]           addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wline_q, wline_d;
    logic [LINE_WIDTH-1:0] rline_q, rline_d;
    logic                  mem_resp_q, mem_resp_d;
    logic [LINE_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic                  bmem_read_q, bmem_read_d;
    logic                  bmem_write_q, bmem_write_d;
    logic [15:0]           bmem_address_q, bmem_address_d;
    logic [BEAT_WIDTH-1:0] bmem_wdata_q, bmem_wdata_d;
`ifdef PMEM_BURST_GUARD_EN
    logic [GUARD_W-1:0]    guard_q, guard_d;
`endif

    logic [BEAT_BITS-1:0]  beatNext;
    logic [LINE_WIDTH-1:0] lineFilled;

    // Beat outputs are precomputed one edge ahead so every bus signal leaves a flop.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        addr_d         = addr_q;
        wline_d        = wline_q;
        rline_d        = rline_q;
        mem_resp_d     = 1'b0;
        mem_rdata_d    = mem_rdata_q;
        bmem_read_d    = bmem_read_q;
        bmem_write_d   = bmem_write_q;
        bmem_address_d = bmem_address_q;
        bmem_wdata_d   = bmem_wdata_q;
`ifdef PMEM_BURST_GUARD_EN
        guard_d        = guard_q;
`endif
        beatNext   = beat_q + 1'b1;
        lineFilled = rline_q;
        lineFilled[int'(beat_q) * BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;

        case (state_q)
            S_IDLE: begin
                if (mem_write || mem_read) begin
                    state_d        = mem_write ? S_WRITE : S_READ;
                    beat_d         = '0;
                    addr_d         = mem_address & LINE_MASK;
                    wline_d        = mem_wdata;
                    bmem_read_d    = !mem_write;
                    bmem_write_d   = mem_write;
                    bmem_address_d = mem_address & LINE_MASK;
                    bmem_wdata_d   = mem_wdata[BEAT_WIDTH-1:0];
                end
            end
            S_READ, S_WRITE: begin
                if (bmem_resp) begin
                    if (state_q == S_READ) begin
                        rline_d = lineFilled;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d      = S_RESP;
                        mem_resp_d   = 1'b1;
                        bmem_read_d  = 1'b0;
                        bmem_write_d = 1'b0;
                        if (state_q == S_READ) begin
                            mem_rdata_d = lineFilled;
                        end
                    end else begin
                        beat_d         = beatNext;
                        bmem_address_d = addr_q | (16'(beatNext) << BYTE_BITS);
                        bmem_wdata_d   = wline_q[int'(beatNext) * BEAT_WIDTH +: BEAT_WIDTH];
                    end
                end
            end
            S_RESP: begin
`ifdef PMEM_BURST_GUARD_EN
                state_d = (GUARD_CYCLES > 0) ? S_GUARD : S_IDLE;
                guard_d = GUARD_W'(GUARD_CYCLES - 1);
`else
                state_d = S_IDLE;
`endif
            end
`ifdef PMEM_BURST_GUARD_EN
            S_GUARD: begin
                if (guard_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    guard_d = guard_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset abandons any partial burst; nothing is replayed afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            beat_q         <= '0;
            addr_q         <= '0;
            wline_q        <= '0;
            rline_q        <= '0;
            mem_resp_q     <= 1'b0;
            mem_rdata_q    <= '0;
            bmem_read_q    <= 1'b0;
            bmem_write_q   <= 1'b0;
            bmem_address_q <= '0;
            bmem_wdata_q   <= '0;
`ifdef PMEM_BURST_GUARD_EN
            guard_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            addr_q         <= addr_d;
            wline_q        <= wline_d;
            rline_q        <= rline_d;
            mem_resp_q     <= mem_resp_d;
            mem_rdata_q    <= mem_rdata_d;
            bmem_read_q    <= bmem_read_d;
            bmem_write_q   <= bmem_write_d;
            bmem_address_q <= bmem_address_d;
            bmem_wdata_q   <= bmem_wdata_d;
`ifdef PMEM_BURST_GUARD_EN
            guard_q        <= guard_d;
`endif
        end
    end

    assign mem_resp     = mem_resp_q;
    assign mem_rdata    = mem_rdata_q;
    assign bmem_read    = bmem_read_q;
    assign bmem_write   = bmem_write_q;
    assign bmem_address = bmem_address_q;
    assign bmem_wdata   = bmem_wdata_q;

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Bench for pmem_burst_adapter: transaction-level beat-queue model, bus responder with wait states,
// directed scenarios and randomized line traffic.
module tb_pmem_burst_adapter;
    localparam int NB = 4;
`ifdef PMEM_BURST_GUARD_EN
    localparam int GUARD = 2;
`else
    localparam int GUARD = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [15:0]  mem_address = '0;
    logic [255:0] mem_wdata = '0;
    logic         mem_resp;
    logic [255:0] mem_rdata;
    logic         bmem_read;
    logic         bmem_write;
    logic [15:0]  bmem_address;
    logic [63:0]  bmem_wdata;
    logic         bmem_resp = 1'b0;
    logic [63:0]  bmem_rdata = '0;

    pmem_burst_adapter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_address (bmem_address),
        .bmem_wdata   (bmem_wdata),
        .bmem_resp    (bmem_resp),
        .bmem_rdata   (bmem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Model: an accepted line becomes a queue of expected beats; each bus response retires the head.
    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
        int          idx;
    } beat_t;

    beat_t        pend[$];
    logic         mWrite = 1'b0;
    logic         mResp = 1'b0;
    int           mGuard = 0;
    logic [255:0] mAsm = '0;
    logic [255:0] mRdata = '0;

    always @(posedge clk or negedge rst_n) begin
        beat_t b;
        if (!rst_n) begin
            pend.delete();
            mWrite = 1'b0;
            mResp  = 1'b0;
            mGuard = 0;
            mAsm   = '0;
            mRdata = '0;
        end else if (mResp) begin
            mResp  = 1'b0;
            mGuard = GUARD;
        end else if (mGuard > 0) begin
            mGuard--;
        end else if (pend.size() > 0) begin
            if (bmem_resp) begin
                if (!mWrite) mAsm[pend[0].idx * 64 +: 64] = bmem_rdata;
                void'(pend.pop_front());
                if (pend.size() == 0) begin
                    mResp = 1'b1;
                    if (!mWrite) mRdata = mAsm;
                end
            end
        end else if (mem_read || mem_write) begin
            mWrite = mem_write;
            for (int i = 0; i < NB; i++) begin
                b.addr = (mem_address & 16'hFFE0) + 16'(8 * i);
                b.data = mem_wdata[64 * i +: 64];
                b.idx  = i;
                pend.push_back(b);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("mem_resp", 256'(mem_resp), 256'(mResp));
            checkOutput("bmem_read", 256'(bmem_read), 256'(pend.size() > 0 && !mWrite));
            checkOutput("bmem_write", 256'(bmem_write), 256'(pend.size() > 0 && mWrite));
            checkOutput("mem_rdata", mem_rdata, mRdata);
            if (pend.size() > 0) begin
                checkOutput("bmem_address", 256'(bmem_address), 256'(pend[0].addr));
                if (mWrite) checkOutput("bmem_wdata", 256'(bmem_wdata), 256'(pend[0].data));
            end
        end
    end

    // Physical-memory responder: answers each beat after memWaits cycles of held request.
    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
        logic        wr;
    } logent_t;

    logent_t beatLog[$];
    int      memWaits = 0;
    int      waitCnt = 0;
    bit      directedData = 1'b1;
    bit      strayReq = 1'b0;
    bit      prevReq = 1'b0;
    int      riseCyc[$];

    always @(negedge clk or negedge rst_n) begin
        logent_t e;
        if (!rst_n) begin
            bmem_resp = 1'b0;
            waitCnt   = 0;
        end else begin
            bmem_resp = 1'b0;
            if (bmem_read || bmem_write) begin
                if (waitCnt >= memWaits) begin
                    waitCnt   = 0;
                    bmem_resp = 1'b1;
                    if (directedData) bmem_rdata = {16{2'b00, bmem_address[4:3]}};
                    else bmem_rdata = {$urandom, $urandom};
                    e.addr = bmem_address;
                    e.data = bmem_write ? bmem_wdata : bmem_rdata;
                    e.wr   = bmem_write;
                    beatLog.push_back(e);
                end else begin
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
                if (strayReq) begin
                    bmem_resp  = 1'b1;
                    bmem_rdata = {$urandom, $urandom};
                    strayReq   = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if ((bmem_read || bmem_write) && !prevReq) riseCyc.push_back(cyc);
        prevReq = bmem_read || bmem_write;
    end

    function automatic logic [255:0] randLine();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic applyStimulus(input bit isWrite, input bit bothHigh, input logic [15:0] addr,
                                 input logic [255:0] wdata, input int waits, input int hold,
                                 output int reqCyc, output int respCyc);
        int n;
        @(negedge clk);
        memWaits    = waits;
        mem_address = addr;
        mem_wdata   = wdata;
        mem_write   = isWrite;
        mem_read    = !isWrite || bothHigh;
        reqCyc      = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_resp && n < 300);
        checkOutput("resp_seen", 256'(mem_resp), 256'(1));
        respCyc = cyc;
        for (int i = 0; i < hold; i++) @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((pend.size() > 0 || mResp || mGuard > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_reached", 256'(pend.size() == 0 && !mResp && mGuard == 0), 256'(1));
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int reqCyc, respCyc, n, rises, nRd, nWr;
        logic [15:0] expAddr [4];
        expAddr = '{16'h1240, 16'h1248, 16'h1250, 16'h1258};

        #12;
        checkOutput("rst_mem_resp", 256'(mem_resp), 256'(0));
        checkOutput("rst_mem_rdata", mem_rdata, 256'(0));
        checkOutput("rst_bmem_read", 256'(bmem_read), 256'(0));
        checkOutput("rst_bmem_write", 256'(bmem_write), 256'(0));
        checkOutput("rst_bmem_address", 256'(bmem_address), 256'(0));
        checkOutput("rst_bmem_wdata", 256'(bmem_wdata), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait read of line 0x1240 with patterned beats.
        directedData = 1'b1;
        beatLog.delete();
        applyStimulus(1'b0, 1'b0, 16'h1240, '0, 0, 0, reqCyc, respCyc);
        checkOutput("rd_latency", 256'(respCyc - reqCyc + 1), 256'(6));
        checkOutput("rd_line", mem_rdata, {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}});
        checkOutput("rd_beats", 256'(beatLog.size()), 256'(4));
        for (int i = 0; i < beatLog.size() && i < 4; i++)
            checkOutput("rd_addr", 256'(beatLog[i].addr), 256'(expAddr[i]));
        @(negedge clk);
        checkOutput("rd_resp_one_cycle", 256'(mem_resp), 256'(0));
        waitIdle();

        // Write of line 0xABC0 with three wait cycles per beat.
        beatLog.delete();
        applyStimulus(1'b1, 1'b0, 16'hABC0, {randLine() >> 64, 64'hDEAD}, 3, 0, reqCyc, respCyc);
        checkOutput("wr_beats", 256'(beatLog.size()), 256'(4));
        if (beatLog.size() > 0) begin
            checkOutput("wr_beat0_addr", 256'(beatLog[0].addr), 256'(16'hABC0));
            checkOutput("wr_beat0_data", 256'(beatLog[0].data), 256'(64'hDEAD));
        end
        waitIdle();

        // Read and write both high: only write beats may appear.
        beatLog.delete();
        applyStimulus(1'b1, 1'b1, 16'h0020, randLine(), 1, 0, reqCyc, respCyc);
        nRd = 0;
        nWr = 0;
        foreach (beatLog[i]) if (beatLog[i].wr) nWr++; else nRd++;
        checkOutput("both_read_beats", 256'(nRd), 256'(0));
        checkOutput("both_write_beats", 256'(nWr), 256'(4));
        waitIdle();

        // Stray bus response while idle.
        rises = riseCyc.size();
        strayReq = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("stray_resp", 256'(mem_resp), 256'(0));
        checkOutput("stray_no_burst", 256'(riseCyc.size()), 256'(rises));

        // Request held three cycles past completion.
        riseCyc.delete();
        applyStimulus(1'b0, 1'b0, 16'h0100, '0, 0, 3, reqCyc, respCyc);
        waitIdle();
`ifdef PMEM_BURST_GUARD_EN
        checkOutput("guard_single_burst", 256'(riseCyc.size()), 256'(1));
`else
        checkOutput("reaccept_bursts", 256'(riseCyc.size()), 256'(2));
        if (riseCyc.size() >= 2)
            checkOutput("reaccept_gap", 256'(riseCyc[1] - respCyc), 256'(2));
`endif

        // Reset after beat 1 of a read, then a fresh read.
        beatLog.delete();
        @(negedge clk);
        memWaits    = 0;
        mem_address = 16'h0300;
        mem_read    = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (beatLog.size() < 2 && n < 50);
        checkOutput("pre_rst_beats", 256'(beatLog.size()), 256'(2));
        rst_n    = 1'b0;
        mem_read = 1'b0;
        #1;
        checkOutput("midrst_mem_resp", 256'(mem_resp), 256'(0));
        checkOutput("midrst_mem_rdata", mem_rdata, 256'(0));
        checkOutput("midrst_bmem_read", 256'(bmem_read), 256'(0));
        checkOutput("midrst_bmem_write", 256'(bmem_write), 256'(0));
        checkOutput("midrst_bmem_address", 256'(bmem_address), 256'(0));
        checkOutput("midrst_bmem_wdata", 256'(bmem_wdata), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        beatLog.delete();
        applyStimulus(1'b0, 1'b0, 16'h0040, '0, 0, 0, reqCyc, respCyc);
        checkOutput("post_rst_beats", 256'(beatLog.size()), 256'(4));
        if (beatLog.size() > 0)
            checkOutput("post_rst_addr", 256'(beatLog[0].addr), 256'(16'h0040));
        waitIdle();

        // Randomized traffic.
        directedData = 1'b0;
        for (int t = 0; t < 40; t++) begin
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                          16'($urandom), randLine(), $urandom_range(0, 3), 0, reqCyc, respCyc);
            if ($urandom_range(0, 3) == 0) begin
                waitIdle();
                strayReq = 1'b1;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        waitIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
